// File: rtl/bt656_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bt656_pkg                                                  |
// | Brief   : Shared constants, field indices and FSM encoding for the   |
// |           BT.656 sync decoder.                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bt656_pkg;

  localparam logic [7:0] C_PRE_FF = 8'hFF;
  localparam logic [7:0] C_PRE_00 = 8'h00;

  localparam int unsigned C_XY_ONE = 7;
  localparam int unsigned C_XY_F   = 6;
  localparam int unsigned C_XY_V   = 5;
  localparam int unsigned C_XY_H   = 4;

  localparam int unsigned C_ERR_XY  = 0;
  localparam int unsigned C_ERR_ODD = 1;
  localparam int unsigned C_ERR_LEN = 2;

  typedef enum logic [2:0] {
    ST_SEARCH = 3'd0,
    ST_PRE1   = 3'd1,
    ST_PRE2   = 3'd2,
    ST_PRE3   = 3'd3,
    ST_ACTIVE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bt656_xy_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bt656_xy_check                                             |
// | Brief   : Splits a BT.656 XY byte into F/V/H and checks protection.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bt656_xy_check
  import bt656_pkg::*;
(
  input  logic [7:0] i_xy,
  output logic       o_f,
  output logic       o_v,
  output logic       o_h,
  output logic       o_valid
);

  logic [3:0] w_p_exp;

  assign o_f     = i_xy[C_XY_F];
  assign o_v     = i_xy[C_XY_V];
  assign o_h     = i_xy[C_XY_H];
  assign w_p_exp = {o_v ^ o_h, o_f ^ o_h, o_f ^ o_v, o_f ^ o_v ^ o_h};
  assign o_valid = i_xy[C_XY_ONE] && (i_xy[3:0] == w_p_exp);

endmodule
`default_nettype wire

// File: rtl/bt656_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bt656_sync_decoder                                         |
// | Brief   : BT.656 SAV/EAV parser producing tagged YCbCr 4:2:2 pixels, |
// |           frame geometry and sticky protocol errors.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bt656_sync_decoder
  import bt656_pkg::*;
#(
  parameter int MAX_W_BITS = 12,
  parameter int MAX_H_BITS = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  enable_i,
  input  logic                  err_clr_i,
  input  logic [7:0]            data_i,
  output logic [15:0]           pix_data_o,
  output logic                  pix_valid_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  locked_o,
  output logic [MAX_W_BITS-1:0] width_o,
  output logic [MAX_H_BITS-1:0] height_o,
  output logic [2:0]            err_o
);

  state_t r_state, w_state_nxt;

  logic w_v, w_h, w_xy_ok;
  logic w_is_code, w_code_ok, w_code_bad, w_sav_act, w_vblank;
  logic w_lock_now, w_enter_active, w_act_byte, w_act_ff, w_flush_out;
  logic [2:0] w_err_set;

  logic        r_phase, r_cap_vld, r_hold_vld, r_flush;
  logic [7:0]  r_chroma;
  logic [15:0] r_cap, r_hold, r_pix_data;
  logic        r_pix_valid, r_sof, r_eol;
  logic        r_locked, r_armed, r_sof_pend, r_ref_vld;
  logic [MAX_W_BITS-1:0] r_pix_cnt, r_ref, r_width;
  logic [MAX_H_BITS-1:0] r_line_cnt, r_height;
  logic [2:0]  r_err;

  bt656_xy_check u_xy_check (
    .i_xy    (data_i),
    .o_f     (),
    .o_v     (w_v),
    .o_h     (w_h),
    .o_valid (w_xy_ok)
  );

  assign w_is_code  = enable_i && (r_state == ST_PRE3);
  assign w_code_ok  = w_is_code && w_xy_ok;
  assign w_code_bad = w_is_code && !w_xy_ok;
  assign w_sav_act  = w_code_ok && !w_h && !w_v;
  assign w_vblank   = w_code_ok && w_v;
  // The SAV that achieves lock already opens its own line.
  assign w_lock_now     = w_sav_act && r_armed;
  assign w_enter_active = w_sav_act && (r_locked || r_armed);
  assign w_act_byte  = enable_i && (r_state == ST_ACTIVE) && (data_i != C_PRE_FF);
  assign w_act_ff    = enable_i && (r_state == ST_ACTIVE) && (data_i == C_PRE_FF);
  assign w_flush_out = enable_i && !r_cap_vld && r_flush && r_hold_vld;

  assign w_err_set[C_ERR_XY]  = w_code_bad;
  assign w_err_set[C_ERR_ODD] = w_act_ff && r_phase;
  assign w_err_set[C_ERR_LEN] = w_flush_out && r_ref_vld && (r_pix_cnt != r_ref);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: if (data_i == C_PRE_FF) w_state_nxt = ST_PRE1;
      ST_PRE1:   w_state_nxt = (data_i == C_PRE_00) ? ST_PRE2 : ST_SEARCH;
      ST_PRE2:   w_state_nxt = (data_i == C_PRE_00) ? ST_PRE3 : ST_SEARCH;
      ST_PRE3:   w_state_nxt = w_enter_active ? ST_ACTIVE : ST_SEARCH;
      ST_ACTIVE: if (data_i == C_PRE_FF) w_state_nxt = ST_PRE1;
      default:   w_state_nxt = ST_SEARCH;
    endcase
    if (!enable_i) w_state_nxt = ST_SEARCH;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= ST_SEARCH;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_phase <= 1'b0;      r_cap_vld <= 1'b0;  r_hold_vld <= 1'b0; r_flush <= 1'b0;
      r_chroma <= '0;       r_cap <= '0;        r_hold <= '0;       r_pix_data <= '0;
      r_pix_valid <= 1'b0;  r_sof <= 1'b0;      r_eol <= 1'b0;
      r_locked <= 1'b0;     r_armed <= 1'b0;    r_sof_pend <= 1'b0; r_ref_vld <= 1'b0;
      r_pix_cnt <= '0;      r_ref <= '0;        r_width <= '0;
      r_line_cnt <= '0;     r_height <= '0;
    end else begin
      r_pix_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_cap_vld   <= 1'b0;
      r_flush     <= w_act_ff;
      if (!enable_i) begin
        // Partial-frame state is dropped so the next frame measures cleanly.
        r_phase <= 1'b0;  r_hold_vld <= 1'b0; r_locked <= 1'b0; r_armed <= 1'b0;
        r_sof_pend <= 1'b0; r_pix_cnt <= '0; r_line_cnt <= '0; r_ref_vld <= 1'b0;
      end else begin
        if (w_act_byte) begin
          if (!r_phase) begin
            r_chroma <= data_i;
          end else begin
            r_cap     <= {r_chroma, data_i};
            r_cap_vld <= 1'b1;
            r_pix_cnt <= r_pix_cnt + 1'b1;
          end
          r_phase <= ~r_phase;
        end
        if (w_act_ff || w_enter_active) r_phase <= 1'b0;
        if (w_enter_active) r_pix_cnt <= '0;

        if (r_cap_vld) begin
          if (r_hold_vld) begin
            r_pix_data  <= r_hold;
            r_pix_valid <= 1'b1;
            r_sof       <= r_sof_pend;
            r_sof_pend  <= 1'b0;
          end
          r_hold     <= r_cap;
          r_hold_vld <= 1'b1;
        end else if (w_flush_out) begin
          r_pix_data  <= r_hold;
          r_pix_valid <= 1'b1;
          r_eol       <= 1'b1;
          r_sof       <= r_sof_pend;
          r_sof_pend  <= 1'b0;
          r_hold_vld  <= 1'b0;
          r_line_cnt  <= r_line_cnt + 1'b1;
          r_pix_cnt   <= '0;
          if (!r_ref_vld) begin
            r_ref     <= r_pix_cnt;
            r_ref_vld <= 1'b1;
          end
        end

        if (w_vblank) begin
          r_armed <= 1'b1;
          if (r_line_cnt != '0) begin
            r_width    <= r_ref;
            r_height   <= r_line_cnt;
            r_line_cnt <= '0;
            r_ref_vld  <= 1'b0;
          end
        end
        // Armed is consumed so every frame gets exactly one sof.
        if (w_lock_now) begin
          r_locked   <= 1'b1;
          r_sof_pend <= 1'b1;
          r_armed    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn)       r_err <= '0;
    else if (err_clr_i) r_err <= '0;
    else                r_err <= r_err | w_err_set;
  end

  assign pix_data_o  = r_pix_data;
  assign pix_valid_o = r_pix_valid;
  assign sof_o       = r_sof;
  assign eol_o       = r_eol;
  assign locked_o    = r_locked;
  assign width_o     = r_width;
  assign height_o    = r_height;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bt656_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bt656_sync_decoder                                      |
// | Brief   : Directed self-checking bench for bt656_sync_decoder.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bt656_sync_decoder;

  logic        ACLK = 1'b0;
  logic        ARESETn, enable_i, err_clr_i;
  logic [7:0]  data_i;
  logic [15:0] pix_data_o;
  logic        pix_valid_o, sof_o, eol_o, locked_o;
  logic [11:0] width_o;
  logic [10:0] height_o;
  logic [2:0]  err_o;

  bt656_sync_decoder #(.MAX_W_BITS(12), .MAX_H_BITS(11)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .enable_i(enable_i), .err_clr_i(err_clr_i),
    .data_i(data_i), .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o),
    .sof_o(sof_o), .eol_o(eol_o), .locked_o(locked_o), .width_o(width_o),
    .height_o(height_o), .err_o(err_o)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0, n_bad = 0;
  int n_pix = 0, n_eol = 0, n_sof = 0, n_stray = 0, cur_len = 0;
  logic [15:0] pix_q[$];
  int sof_idx_q[$];
  int line_len_q[$];
  int s, e, f, lq, p0, bad;

  // Output monitor, sampled just after the active edge.
  always @(posedge ACLK) begin
    #1;
    if (!enable_i) cur_len = 0;
    if (pix_valid_o) begin
      pix_q.push_back(pix_data_o);
      if (sof_o) begin sof_idx_q.push_back(n_pix); n_sof++; end
      n_pix++;
      cur_len++;
      if (eol_o) begin line_len_q.push_back(cur_len); cur_len = 0; n_eol++; end
    end else if (sof_o || eol_o) begin
      n_stray++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xy_byte(input bit fb, input bit v, input bit h);
    return {1'b1, fb, v, h, v ^ h, fb ^ h, fb ^ v, fb ^ v ^ h};
  endfunction

  function automatic logic [7:0] act_byte(input int i);
    return 8'((i % 14 + 1) * 16);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    data_i = b;
    @(negedge ACLK);
  endtask

  task automatic send_code(input bit v, input bit h, input bit corrupt);
    logic [7:0] xy;
    xy = xy_byte(1'b0, v, h);
    if (corrupt) xy[0] = ~xy[0];
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(xy);
  endtask

  task automatic send_line(input bit v, input int nbytes, input bit corrupt);
    send_code(v, 1'b0, corrupt);
    for (int i = 0; i < nbytes; i++) send_byte(v ? 8'h80 : act_byte(i));
    send_code(v, 1'b1, 1'b0);
    repeat (4) send_byte(8'h80);
  endtask

  task automatic send_frame(input int nlines, input int nbytes);
    send_line(1'b1, 4, 1'b0);
    send_line(1'b1, 4, 1'b0);
    for (int l = 0; l < nlines; l++) send_line(1'b0, nbytes, 1'b0);
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge ACLK);
    err_clr_i = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0; enable_i = 1'b0; err_clr_i = 1'b0; data_i = 8'h80;
    repeat (3) @(negedge ACLK);
    chk("rst_pix_valid", pix_valid_o, 0);
    chk("rst_pix_data", pix_data_o, 0);
    chk("rst_sof", sof_o, 0);
    chk("rst_eol", eol_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_width", width_o, 0);
    chk("rst_height", height_o, 0);
    chk("rst_err", err_o, 0);
    ARESETn = 1'b1; enable_i = 1'b1;

    // Frame A: 16x10
    send_line(1'b1, 4, 1'b0);
    send_line(1'b1, 4, 1'b0);
    chk("lock_before_sav", locked_o, 0);
    s = n_pix; e = n_eol; f = n_sof; lq = line_len_q.size();
    for (int l = 0; l < 10; l++) send_line(1'b0, 32, 1'b0);
    chk("a_locked", locked_o, 1);
    chk("a_pix_count", n_pix - s, 160);
    chk("a_eol_count", n_eol - e, 10);
    chk("a_sof_count", n_sof - f, 1);
    chk("a_pix0", pix_q[s], 16'h1020);
    chk("a_pix1", pix_q[s + 1], 16'h3040);
    chk("a_pix6", pix_q[s + 6], 16'hD0E0);
    chk("a_pix7", pix_q[s + 7], 16'h1020);
    chk("a_sof_first", (sof_idx_q.size() > 0) ? sof_idx_q[sof_idx_q.size() - 1] : -1, s);
    bad = 0;
    for (int i = lq; i < line_len_q.size(); i++) if (line_len_q[i] != 16) bad++;
    chk("a_line_len", bad, 0);

    // Frame B: its blanking publishes frame A geometry
    send_line(1'b1, 4, 1'b0);
    chk("b_width", width_o, 16);
    chk("b_height", height_o, 10);
    chk("b_err", err_o, 0);
    send_line(1'b1, 4, 1'b0);
    s = n_pix; f = n_sof;
    for (int l = 0; l < 10; l++) send_line(1'b0, 32, 1'b0);
    chk("b_pix_count", n_pix - s, 160);
    chk("b_sof_count", n_sof - f, 1);

    // Frame C: corrupted SAV on line 3
    send_line(1'b1, 4, 1'b0);
    chk("c_width", width_o, 16);
    chk("c_height", height_o, 10);
    send_line(1'b1, 4, 1'b0);
    for (int l = 0; l < 3; l++) send_line(1'b0, 32, 1'b0);
    s = n_pix;
    send_line(1'b0, 32, 1'b1);
    chk("c_bad_line_pix", n_pix - s, 0);
    chk("c_err_xy", err_o, 3'b001);
    s = n_pix;
    for (int l = 4; l < 10; l++) send_line(1'b0, 32, 1'b0);
    chk("c_resync_pix", n_pix - s, 96);
    pulse_clr();
    chk("c_err_clr", err_o, 0);

    // Frame D: 32 / 33 / 34 byte lines
    send_line(1'b1, 4, 1'b0);
    chk("d_height_prev", height_o, 9);
    send_line(1'b1, 4, 1'b0);
    send_line(1'b0, 32, 1'b0);
    send_line(1'b0, 33, 1'b0);
    chk("d_err_odd", err_o, 3'b010);
    chk("d_odd_pix", line_len_q[line_len_q.size() - 1], 16);
    pulse_clr();
    send_line(1'b0, 34, 1'b0);
    chk("d_err_len", err_o, 3'b100);
    chk("d_long_pix", line_len_q[line_len_q.size() - 1], 17);
    pulse_clr();

    // Frame E: enable dropped mid-line 0
    send_line(1'b1, 4, 1'b0);
    chk("e_height_prev", height_o, 3);
    chk("e_err", err_o, 0);
    send_line(1'b1, 4, 1'b0);
    send_code(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(act_byte(i));
    p0 = n_pix;
    enable_i = 1'b0;
    for (int i = 10; i < 15; i++) begin
      send_byte(act_byte(i));
      chk("gap_locked", locked_o, 0);
    end
    chk("gap_no_pix", n_pix, p0);
    enable_i = 1'b1;
    for (int i = 15; i < 32; i++) send_byte(act_byte(i));
    send_code(1'b0, 1'b1, 1'b0);
    repeat (4) send_byte(8'h80);
    for (int l = 1; l < 10; l++) send_line(1'b0, 32, 1'b0);
    chk("no_pix_until_sof", n_pix, p0);
    s = n_pix; e = n_eol; f = n_sof;
    send_frame(10, 32);
    chk("f_pix_count", n_pix - s, 160);
    chk("f_eol_count", n_eol - e, 10);
    chk("f_sof_count", n_sof - f, 1);
    chk("f_sof_first", (sof_idx_q.size() > 0) ? sof_idx_q[sof_idx_q.size() - 1] : -1, s);
    send_line(1'b1, 4, 1'b0);
    chk("f_width", width_o, 16);
    chk("f_height", height_o, 10);

    // Reset, then a stream starting mid-frame
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    chk("rst2_width", width_o, 0);
    s = n_pix;
    for (int l = 0; l < 3; l++) send_line(1'b0, 32, 1'b0);
    chk("mid_no_pix", n_pix - s, 0);
    send_line(1'b1, 4, 1'b0);
    send_line(1'b1, 4, 1'b0);
    chk("mid_unlocked", locked_o, 0);
    send_code(1'b0, 1'b0, 1'b0);
    chk("mid_lock_on_sav", locked_o, 1);
    for (int i = 0; i < 32; i++) begin
      send_byte(act_byte(i));
      if (i == 3) chk("lat_not_yet", n_pix - s, 0);
      if (i == 4) chk("lat_3cyc", n_pix - s, 1);
    end
    e = n_eol;
    send_byte(8'hFF);
    chk("eol_lat_early", n_eol, e);
    send_byte(8'h00);
    chk("eol_lat_1cyc", n_eol, e + 1);
    send_byte(8'h00);
    send_byte(xy_byte(1'b0, 1'b0, 1'b1));
    repeat (4) send_byte(8'h80);
    chk("mid_line0_pix", n_pix - s, 16);
    chk("mid_sof_first", (sof_idx_q.size() > 0) ? sof_idx_q[sof_idx_q.size() - 1] : -1, s);
    for (int l = 1; l < 4; l++) send_line(1'b0, 32, 1'b0);
    send_line(1'b1, 4, 1'b0);
    chk("mid_width", width_o, 16);
    chk("mid_height", height_o, 4);
    chk("mid_err", err_o, 0);
    chk("stray_flags", n_stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
